// File: rtl/dbus_ram_responder_pkg.sv
// Shared data-bus types plus the responder's FSM state type and size helper.
package dbus_ram_responder_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dram_state_t;

    function automatic logic [3:0] msize_bytes(msize_t sz);
        case (sz)
            MSIZE1:  return 4'd1;
            MSIZE2:  return 4'd2;
            MSIZE4:  return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/dbus_ram_responder_if.sv
// Data-bus request/response bundle between the core (master) and memory (slave).
interface dbus_ram_responder_if;
    import dbus_ram_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;
    logic       err;

    modport master (output dreq, input dresp, input err);
    modport slave  (input dreq, output dresp, output err);

endinterface

// File: rtl/dbus_ram_array.sv
// 2^AW x 64-bit storage: combinational read, synchronous byte-enabled write.
module dbus_ram_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [7:0]    wstrb,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [63:0]   rdata
);

    // One array per byte lane keeps each lane a plain single-writer memory.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [2**AW];

            always_ff @(posedge clk) begin
                if (we && wstrb[gi]) begin
                    lane_mem[widx] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[ridx];
        end
    endgenerate

endmodule

// File: rtl/dbus_ram_responder.sv
// Fixed-latency RAM responder for the data bus; one transaction in flight at a time.
module dbus_ram_responder
    import dbus_ram_responder_pkg::*;
#(
    parameter int          AW      = 12,
    parameter int          LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_ram_responder_if.slave  bus
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("dbus_ram_responder: LATENCY must be in 1..15");
        end
        if (BASE[2:0] != 3'd0) begin : g_bad_base
            $error("dbus_ram_responder: BASE must be 8-byte aligned");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dram_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    msize_t      size_q, size_d;
    logic [7:0]  strobe_q, strobe_d;
    logic [63:0] wdata_q, wdata_d;
    dbus_resp_t  resp_q, resp_d;
    logic        err_q, err_d;

    logic [63:0]   offset;
    logic [3:0]    nbytes;
    logic          in_range;
    logic          aligned;
    logic          txn_ok;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic [63:0]   ram_rdata;

    // Decode works only on the latched request, so the bus may change freely.
    assign offset   = addr_q - BASE;
    assign nbytes   = msize_bytes(size_q);
    assign in_range = (addr_q >= BASE) && (offset[63:AW+3] == '0);
    assign aligned  = (({1'b0, offset[2:0]} & (nbytes - 4'd1)) == 4'd0);
    assign txn_ok   = in_range && aligned;
    assign ram_idx  = offset[AW+2:3];
    assign ram_we   = (state_q == RESP) && txn_ok && (strobe_q != 8'd0);

    dbus_ram_array #(
        .AW (AW)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .widx  (ram_idx),
        .wstrb (strobe_q),
        .wdata (wdata_q),
        .ridx  (ram_idx),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        resp_d   = '0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.dreq.valid) begin
                    addr_d   = bus.dreq.addr;
                    size_d   = bus.dreq.size;
                    strobe_d = bus.dreq.strobe;
                    wdata_d  = bus.dreq.data;
                    cnt_d    = CNT_INIT;
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // Read data is taken before this edge's write lands in the array.
                resp_d.addr_ok = 1'b1;
                resp_d.data_ok = 1'b1;
                resp_d.data    = txn_ok ? ram_rdata : 64'd0;
                err_d          = ~txn_ok;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 64'd0;
            size_q   <= MSIZE1;
            strobe_q <= 8'd0;
            wdata_q  <= 64'd0;
            resp_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            resp_q   <= resp_d;
            err_q    <= err_d;
        end
    end

    assign bus.dresp = resp_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder at LATENCY=2, AW=12, BASE=0x8000_0000.
module tb_dbus_ram_responder;
    import dbus_ram_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    dbus_ram_responder_if bus();

    dbus_ram_responder #(
        .AW      (12),
        .LATENCY (2),
        .BASE    (64'h8000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "/addr_ok"}, 64'(bus.dresp.addr_ok), 64'd0);
        check_eq({tag, "/data_ok"}, 64'(bus.dresp.data_ok), 64'd0);
        check_eq({tag, "/err"},     64'(bus.err),           64'd0);
    endtask

    // Issues one request, checks the handshake lands exactly at T+2, returns data/err.
    task automatic do_txn(input string tag, input logic [63:0] addr, input msize_t size,
                          input logic [7:0] strb, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic rerr);
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = addr;
        bus.dreq.size   = size;
        bus.dreq.strobe = strb;
        bus.dreq.data   = wdata;
        tick();
        bus.dreq.valid = 1'b0;
        check_eq({tag, "/data_ok@T"}, 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq({tag, "/data_ok@T+1"}, 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq({tag, "/addr_ok@T+2"}, 64'(bus.dresp.addr_ok), 64'd1);
        check_eq({tag, "/data_ok@T+2"}, 64'(bus.dresp.data_ok), 64'd1);
        rdata = bus.dresp.data;
        rerr  = bus.err;
        tick();
        check_quiet({tag, "@T+3"});
        $display("txn %s addr=%h size=%0d strb=%h wdata=%h -> data=%h err=%b",
                 tag, addr, size, strb, wdata, rdata, rerr);
    endtask

    initial begin
        logic [63:0] rd;
        logic        re;

        reset           = 1'b1;
        bus.dreq.valid  = 1'b0;
        bus.dreq.addr   = 64'd0;
        bus.dreq.size   = MSIZE8;
        bus.dreq.strobe = 8'd0;
        bus.dreq.data   = 64'd0;
        tick();
        tick();
        check_quiet("in_reset");
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick();
            check_quiet("idle");
            check_eq("idle/data", bus.dresp.data, 64'd0);
        end

        do_txn("wr_w0", 64'h8000_0000, MSIZE8, 8'hFF, 64'h1111_2222_3333_4444, rd, re);
        check_eq("wr_w0/err", 64'(re), 64'd0);

        do_txn("wr_full", 64'h8000_0010, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0123_4567, rd, re);
        check_eq("wr_full/err", 64'(re), 64'd0);
        do_txn("rd_full", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_full/data", rd, 64'hDEAD_BEEF_0123_4567);
        check_eq("rd_full/err", 64'(re), 64'd0);

        do_txn("wr_part", 64'h8000_0010, MSIZE8, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, rd, re);
        check_eq("wr_part/old_data", rd, 64'hDEAD_BEEF_0123_4567);
        do_txn("rd_part", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_part/data", rd, 64'hDEAD_BEEF_AAAA_BBBB);

        do_txn("rd_below", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_below/data", rd, 64'd0);
        check_eq("rd_below/err", 64'(re), 64'd1);

        do_txn("wr_above", 64'h8000_8000, MSIZE8, 8'hFF, 64'h0BAD_0BAD_0BAD_0BAD, rd, re);
        check_eq("wr_above/data", rd, 64'd0);
        check_eq("wr_above/err", 64'(re), 64'd1);
        do_txn("rd_probe0", 64'h8000_0000, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_probe0/data", rd, 64'h1111_2222_3333_4444);

        do_txn("rd_w4_mis", 64'h8000_0012, MSIZE4, 8'h00, 64'd0, rd, re);
        check_eq("rd_w4_mis/data", rd, 64'd0);
        check_eq("rd_w4_mis/err", 64'(re), 64'd1);
        do_txn("rd_w4_ok", 64'h8000_0014, MSIZE4, 8'h00, 64'd0, rd, re);
        check_eq("rd_w4_ok/err", 64'(re), 64'd0);
        check_eq("rd_w4_ok/data", rd, 64'hDEAD_BEEF_AAAA_BBBB);

        do_txn("wr_h_mis", 64'h8000_0011, MSIZE2, 8'h06, 64'h0000_0000_0077_7700, rd, re);
        check_eq("wr_h_mis/err", 64'(re), 64'd1);
        do_txn("rd_after_mis", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_after_mis/data", rd, 64'hDEAD_BEEF_AAAA_BBBB);

        // Back-to-back with valid held high across both requests.
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h8000_0010;
        bus.dreq.size   = MSIZE8;
        bus.dreq.strobe = 8'h00;
        tick();
        check_eq("b2b/data_ok@T", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq("b2b/data_ok@T+1", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq("b2b/data_ok@T+2", 64'(bus.dresp.data_ok), 64'd1);
        check_eq("b2b/data1", bus.dresp.data, 64'hDEAD_BEEF_AAAA_BBBB);
        bus.dreq.addr = 64'h8000_0000;
        tick();
        check_eq("b2b/data_ok@T+3", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq("b2b/data_ok@T+4", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq("b2b/data_ok@T+5", 64'(bus.dresp.data_ok), 64'd1);
        check_eq("b2b/data2", bus.dresp.data, 64'h1111_2222_3333_4444);
        bus.dreq.valid = 1'b0;
        tick();
        check_eq("b2b/data_ok@T+6", 64'(bus.dresp.data_ok), 64'd0);
        tick();
        check_eq("b2b/data_ok@T+7", 64'(bus.dresp.data_ok), 64'd0);
        $display("txn b2b reads 80000010 then 80000000 with valid held");

        do_txn("wr_w4", 64'h8000_0020, MSIZE8, 8'hFF, 64'h5555_6666_7777_8888, rd, re);
        check_eq("wr_w4/err", 64'(re), 64'd0);

        // Reset lands while the write is in its RESP cycle, before the commit edge.
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h8000_0020;
        bus.dreq.size   = MSIZE8;
        bus.dreq.strobe = 8'hFF;
        bus.dreq.data   = 64'hAAAA_AAAA_AAAA_AAAA;
        tick();
        bus.dreq.valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check_eq("rst_mid/data_ok", 64'(bus.dresp.data_ok), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_quiet("rst_mid/held");
        end
        reset = 1'b0;
        tick();
        check_quiet("rst_mid/after");
        tick();
        check_quiet("rst_mid/after2");
        $display("txn rst_mid write 80000020 aborted by reset");
        do_txn("rd_w4", 64'h8000_0020, MSIZE8, 8'h00, 64'd0, rd, re);
        check_eq("rd_w4/data", rd, 64'h5555_6666_7777_8888);
        check_eq("rd_w4/err", 64'(re), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
